ptw_mem_arbiter: RTL and testbench
==================================

Name: ptw_mem_arbiter

Overview:
- Shares one page-table-walk memory read port between the instruction-side MMU (IFU) and the data-side MMU (LSU).
- Arbitration is round-robin with one outstanding read. The block latches the walk address, handshakes with memory and routes the read response back to the owning MMU.
- It discards responses for walks killed by a flush and raises a watchdog timeout if memory never responds.

Parameters:
- TIMEOUT_CYCLES, 255, cycles waiting for mem_rvalid_i (WAIT or DRAIN) before the walk is abandoned; must satisfy 1 ≤ TIMEOUT_CYCLES ≤ 2^CNT_W−1.
- CNT_W, 8, width of the watchdog counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- ifu_ptw_req_i  in  1  IFU MMU walk read request (level; held until its rvalid)
- ifu_ptw_addr_i  in  32  IFU PTE physical address
- ifu_ptw_rdata_o  out  32  PTE data to IFU MMU
- ifu_ptw_rvalid_o  out  1  one-cycle response pulse to IFU MMU
- ifu_ptw_err_o  out  1  qualifies ifu_ptw_rvalid_o: walk timed out
- lsu_ptw_req_i / lsu_ptw_addr_i / lsu_ptw_rdata_o / lsu_ptw_rvalid_o / lsu_ptw_err_o  same as IFU set, for the LSU MMU
- mem_req_o  out  1  read request to memory
- mem_addr_o  out  32  read address
- mem_ready_i  in  1  memory accepts the request this cycle (mem_req_o && mem_ready_i)
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data
- flush_i  in  1  sfence/satp change: kill any walk
- ifu_flush_i  in  1  IFU redirect: kill the walk only if IFU owns it
- busy_o  out  1  state != IDLE
- grant_o  out  2  current owner one-hot {lsu,ifu}; 00 in IDLE
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, grant_o = 00, last_grant = LSU (so IFU wins first), counter = 0, kill = 0.
  - All outputs 0, including mem_addr_o and both rdata outputs.
- States:
  - IDLE:
    - If flush_i is high, no grant is made this cycle.
    - Otherwise, if any request is masked-valid, grant it. ifu_flush_i masks the IFU request this cycle.
    - Both requesting: grant the requester that is not last_grant.
    - Latch the owner's address into addr_q and update last_grant. Next state is REQ.
    - Arbitration latency is one cycle: mem_req_o rises the cycle after the request is seen.
  - REQ:
    - mem_req_o = 1 and mem_addr_o = addr_q; both are held stable until mem_ready_i.
    - A request is never withdrawn once asserted, even on flush.
    - A flush hitting the owner sets kill.
    - On accept: go to DRAIN if kill is set (or a flush arrives in the same cycle), else WAIT. Counter clears.
  - WAIT:
    - mem_req_o = 0. Counter increments each cycle and saturates.
    - mem_rvalid_i: drive the owner's rvalid_o = 1 for one cycle with rdata_o = mem_rdata_i and err = 0, then go to IDLE.
    - Flush without rvalid in the same cycle: go to DRAIN.
    - Flush in the same cycle as rvalid: the response is still delivered. Flush has lower priority than a completing response.
  - DRAIN:
    - Wait for mem_rvalid_i, then go to IDLE. No rvalid is delivered to either MMU.
    - Flushes are ignored here.
- Watchdog:
  - In WAIT: when counter == TIMEOUT_CYCLES−1 with no rvalid, pulse timeout_o. Deliver owner rvalid = 1, err = 1, rdata = 0, then go to IDLE.
  - In DRAIN: same condition pulses timeout_o and goes to IDLE, with no delivery.
  - An mem_rvalid_i arriving in IDLE (late, after a timeout) is ignored.
- Routing:
  - rvalid/err/rdata are asserted only toward the grant_o owner; the non-owner's outputs stay 0.
  - rdata outputs are 0 whenever the matching rvalid is 0.
- Requester rule:
  - A requester must drop req the cycle after its rvalid. A req still high in IDLE is treated as a new walk.
  - Address changes while not granted are allowed; addr is sampled only at grant.
- The arbiter is non-preemptive: the owner keeps the port until completion, kill or timeout.
- Reset mid-walk returns to IDLE immediately. Any later mem_rvalid_i from the aborted read is ignored in IDLE.

Test Plan:
- IFU only, addr 0x8000_1004, mem_ready_i high, rvalid 3 cycles later with 0x2000_00CF:
  - mem_req_o is high exactly 1 cycle with addr 0x8000_1004.
  - ifu_ptw_rvalid_o pulses once with 0x2000_00CF; lsu outputs stay 0.
- IFU and LSU request in the same cycle from reset:
  - IFU is granted first, then LSU.
  - With both requests re-raised continuously, grants alternate IFU, LSU, IFU, LSU across 4 walks.
- mem_ready_i held low 5 cycles in REQ:
  - mem_req_o and mem_addr_o stay stable for all 5 cycles.
  - Accept happens on cycle 6.
- LSU owns the walk in WAIT, ifu_flush_i pulses: no effect, LSU gets its data.
- LSU owns the walk in WAIT, flush_i pulses: state goes to DRAIN, the later rvalid is dropped, and neither rvalid_o fires.
- TIMEOUT_CYCLES = 4, memory never responds:
  - timeout_o pulses 4 cycles after accept.
  - Owner gets rvalid = 1, err = 1, rdata = 0, and busy_o is low the next cycle.
  - A late rvalid afterwards is ignored.
- rst_n asserted in WAIT: all outputs 0 asynchronously, and a subsequent mem_rvalid_i produces no rvalid to either MMU.

Source files
------------

// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: round-robin share of one PTW memory read port between IFU and LSU MMUs,
// one outstanding read, flush kill with response drain, and a response watchdog.
module ptw_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_ptw_req_i,
    input  logic [31:0] ifu_ptw_addr_i,
    output logic [31:0] ifu_ptw_rdata_o,
    output logic        ifu_ptw_rvalid_o,
    output logic        ifu_ptw_err_o,
    input  logic        lsu_ptw_req_i,
    input  logic [31:0] lsu_ptw_addr_i,
    output logic [31:0] lsu_ptw_rdata_o,
    output logic        lsu_ptw_rvalid_o,
    output logic        lsu_ptw_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        flush_i,
    input  logic        ifu_flush_i,
    output logic        busy_o,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t             r_state;
    logic [1:0]         r_grant;
    logic               r_last_lsu;
    logic               r_kill;
    logic [31:0]        r_addr;
    logic [CNT_W-1:0]   r_cnt;

    logic w_pick_ifu, w_pick_lsu, w_hit, w_to, w_deliver, w_done;

    // ifu_flush_i masks only the IFU request; flush_i blocks any grant
    assign w_pick_ifu = !flush_i && ifu_ptw_req_i && !ifu_flush_i && (!lsu_ptw_req_i || r_last_lsu);
    assign w_pick_lsu = !flush_i && lsu_ptw_req_i && !w_pick_ifu;
    assign w_hit      = flush_i || (ifu_flush_i && r_grant[0]);
    assign w_to       = (r_state == S_WAIT || r_state == S_DRAIN) && !mem_rvalid_i
                        && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_done     = mem_rvalid_i || w_to;
    assign w_deliver  = r_state == S_WAIT && w_done;

    assign ifu_ptw_rvalid_o = w_deliver && r_grant[0];
    assign lsu_ptw_rvalid_o = w_deliver && r_grant[1];
    assign ifu_ptw_err_o    = ifu_ptw_rvalid_o && w_to;
    assign lsu_ptw_err_o    = lsu_ptw_rvalid_o && w_to;
    assign ifu_ptw_rdata_o  = (ifu_ptw_rvalid_o && !w_to) ? mem_rdata_i : '0;
    assign lsu_ptw_rdata_o  = (lsu_ptw_rvalid_o && !w_to) ? mem_rdata_i : '0;
    assign mem_req_o        = r_state == S_REQ;
    assign mem_addr_o       = mem_req_o ? r_addr : '0;
    assign busy_o           = r_state != S_IDLE;
    assign grant_o          = r_grant;
    assign timeout_o        = w_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'b00;
            r_last_lsu <= 1'b1;
            r_kill     <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_pick_ifu || w_pick_lsu) begin
                    r_state    <= S_REQ;
                    r_grant    <= {w_pick_lsu, w_pick_ifu};
                    r_last_lsu <= w_pick_lsu;
                    r_addr     <= w_pick_ifu ? ifu_ptw_addr_i : lsu_ptw_addr_i;
                    r_kill     <= 1'b0;
                end
                S_REQ: begin
                    if (w_hit) r_kill <= 1'b1;
                    if (mem_ready_i) begin
                        r_state <= (r_kill || w_hit) ? S_DRAIN : S_WAIT;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                    // a completing response outranks a same-cycle flush
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                    end else if (w_hit) begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter: directed checks of arbitration, routing, flush drain, watchdog and reset.
module tb_ptw_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req, lsu_req, mem_ready, mem_rvalid, flush, ifu_flush;
    logic [31:0] ifu_addr, lsu_addr, mem_rdata;
    logic [31:0] ifu_rdata, lsu_rdata, mem_addr;
    logic        ifu_rvalid, lsu_rvalid, ifu_err, lsu_err, mem_req, busy, timeout;
    logic [1:0]  grant;
    int          nchk = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    ptw_mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_ptw_req_i(ifu_req), .ifu_ptw_addr_i(ifu_addr), .ifu_ptw_rdata_o(ifu_rdata),
        .ifu_ptw_rvalid_o(ifu_rvalid), .ifu_ptw_err_o(ifu_err),
        .lsu_ptw_req_i(lsu_req), .lsu_ptw_addr_i(lsu_addr), .lsu_ptw_rdata_o(lsu_rdata),
        .lsu_ptw_rvalid_o(lsu_rvalid), .lsu_ptw_err_o(lsu_err),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ready_i(mem_ready),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .flush_i(flush), .ifu_flush_i(ifu_flush),
        .busy_o(busy), .grant_o(grant), .timeout_o(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {ifu_req, lsu_req, mem_ready, mem_rvalid, flush, ifu_flush} = '0;
        ifu_addr = '0; lsu_addr = '0; mem_rdata = '0;
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalids", 32'({ifu_rvalid, lsu_rvalid, ifu_err, lsu_err, timeout}), 0);
        chk("rst_rdata", ifu_rdata | lsu_rdata, 0);
        nxt; rst_n = 1'b1;

        // IFU-only walk, response in the third WAIT cycle
        ifu_req = 1'b1; ifu_addr = 32'h8000_1004; mem_ready = 1'b1;
        #1 chk("s1_idle_mem_req", 32'(mem_req), 0);
        nxt;
        chk("s1_req", 32'(mem_req), 1);
        chk("s1_addr", mem_addr, 32'h8000_1004);
        chk("s1_grant", 32'(grant), 1);
        nxt;
        chk("s1_req_one_cycle", 32'(mem_req), 0);
        nxt; nxt;
        mem_rvalid = 1'b1; mem_rdata = 32'h2000_00CF;
        #1;
        chk("s1_ifu_rvalid", 32'(ifu_rvalid), 1);
        chk("s1_ifu_rdata", ifu_rdata, 32'h2000_00CF);
        chk("s1_ifu_err", 32'(ifu_err), 0);
        chk("s1_lsu_quiet", 32'({lsu_rvalid, lsu_err}) | lsu_rdata, 0);
        nxt; mem_rvalid = 1'b0; ifu_req = 1'b0;
        #1;
        chk("s1_ifu_rvalid_drop", 32'(ifu_rvalid), 0);
        chk("s1_idle", 32'(busy), 0);

        // simultaneous requests from reset alternate IFU, LSU, IFU, LSU
        rst_n = 1'b0;
        nxt; rst_n = 1'b1;
        ifu_req = 1'b1; lsu_req = 1'b1; ifu_addr = 32'h0000_1000; lsu_addr = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            nxt;
            chk("s2_grant", 32'(grant), (i % 2) ? 2 : 1);
            chk("s2_addr", mem_addr, (i % 2) ? 32'h0000_2000 : 32'h0000_1000);
            nxt;
            mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0000 + 32'(i);
            #1;
            chk("s2_ifu_rvalid", 32'(ifu_rvalid), (i % 2) ? 0 : 1);
            chk("s2_lsu_rvalid", 32'(lsu_rvalid), (i % 2) ? 1 : 0);
            chk("s2_owner_rdata", (i % 2) ? lsu_rdata : ifu_rdata, 32'hA5A5_0000 + 32'(i));
            chk("s2_other_rdata", (i % 2) ? ifu_rdata : lsu_rdata, 0);
            nxt; mem_rvalid = 1'b0;
            #1 chk("s2_idle", 32'(busy), 0);
        end
        ifu_req = 1'b0; lsu_req = 1'b0;

        // memory stalls 5 cycles; address sampled only at grant
        lsu_req = 1'b1; lsu_addr = 32'h3000_0040; mem_ready = 1'b0;
        nxt;
        lsu_addr = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("s3_req_stable", 32'(mem_req), 1);
            chk("s3_addr_stable", mem_addr, 32'h3000_0040);
            nxt;
        end
        mem_ready = 1'b1;
        #1 chk("s3_req_cycle6", 32'(mem_req), 1);
        nxt;
        chk("s3_accepted", 32'(mem_req), 0);
        chk("s3_busy", 32'(busy), 1);

        // ifu_flush_i does not touch an LSU-owned walk
        ifu_flush = 1'b1;
        #1 chk("s4_no_early_rvalid", 32'(lsu_rvalid), 0);
        nxt; ifu_flush = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("s4_lsu_rvalid", 32'(lsu_rvalid), 1);
        chk("s4_lsu_rdata", lsu_rdata, 32'h1234_5678);
        chk("s4_ifu_rvalid", 32'(ifu_rvalid), 0);
        chk("s4_timeout", 32'(timeout), 0);
        nxt; mem_rvalid = 1'b0; lsu_req = 1'b0;
        #1 chk("s4_idle", 32'(busy), 0);

        // flush_i in WAIT drains the response
        lsu_req = 1'b1; lsu_addr = 32'h4000_0000;
        nxt; nxt;
        flush = 1'b1; lsu_req = 1'b0;
        nxt; flush = 1'b0;
        #1;
        chk("s5_drain_busy", 32'(busy), 1);
        chk("s5_drain_grant", 32'(grant), 2);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0000;
        #1 chk("s5_dropped", 32'({ifu_rvalid, lsu_rvalid}) | ifu_rdata | lsu_rdata, 0);
        nxt; mem_rvalid = 1'b0;
        #1 chk("s5_idle", 32'(busy), 0);

        // watchdog with no response
        ifu_req = 1'b1; ifu_addr = 32'h5000_0000; mem_rdata = 32'hFFFF_FFFF;
        nxt; nxt;
        for (int k = 0; k < 3; k++) begin
            #1 chk("s6_no_timeout", 32'(timeout), 0);
            nxt;
        end
        #1;
        chk("s6_timeout", 32'(timeout), 1);
        chk("s6_ifu_rvalid", 32'(ifu_rvalid), 1);
        chk("s6_ifu_err", 32'(ifu_err), 1);
        chk("s6_ifu_rdata", ifu_rdata, 0);
        chk("s6_lsu_quiet", 32'({lsu_rvalid, lsu_err}), 0);
        nxt; ifu_req = 1'b0;
        #1;
        chk("s6_idle", 32'(busy), 0);
        chk("s6_timeout_pulse", 32'(timeout), 0);
        mem_rvalid = 1'b1;
        #1 chk("s6_late_ignored", 32'({ifu_rvalid, lsu_rvalid}), 0);
        nxt; mem_rvalid = 1'b0;

        // flush_i blocks grant in IDLE; ifu_flush_i in REQ kills the walk
        ifu_req = 1'b1; flush = 1'b1;
        nxt; flush = 1'b0;
        #1 chk("s7_no_grant", 32'(busy), 0);
        nxt;
        chk("s7_grant", 32'(grant), 1);
        mem_ready = 1'b0; ifu_flush = 1'b1;
        nxt; ifu_flush = 1'b0; mem_ready = 1'b1;
        #1 chk("s7_req_held", 32'(mem_req), 1);
        nxt; ifu_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        chk("s7_killed", 32'({ifu_rvalid, lsu_rvalid}), 0);
        chk("s7_drain_busy", 32'(busy), 1);
        nxt; mem_rvalid = 1'b0;
        #1 chk("s7_idle", 32'(busy), 0);

        // asynchronous reset while in WAIT
        lsu_req = 1'b1; lsu_addr = 32'h6000_0000;
        nxt; nxt;
        chk("s8_wait_busy", 32'(busy), 1);
        rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
        #1;
        chk("s8_async_busy", 32'(busy), 0);
        chk("s8_async_grant", 32'(grant), 0);
        chk("s8_async_quiet", 32'({mem_req, ifu_rvalid, lsu_rvalid, timeout}) | mem_addr | lsu_rdata, 0);
        lsu_req = 1'b0;
        nxt; rst_n = 1'b1;
        #1 chk("s8_post_rvalid", 32'({ifu_rvalid, lsu_rvalid}), 0);
        nxt; mem_rvalid = 1'b0;
        #1 chk("s8_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
